mem_tester: RTL and testbench

- Simulation/verification memory window attached to the reflet CPU data bus.
- Behaves as a small word RAM mapped at a fixed base address. Read data goes onto an OR-combined bus.
- Continuously compares its whole contents with a packed expected pattern and flags a match on content_ok.
- Used by CPU test benches to check that a program stored the correct results.

---
 rtl/mem_tester.sv | 52 +++++
 tb/tb_mem_tester.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_tester.sv
// Memory window on the CPU data bus: small word RAM at a fixed base address with
// registered OR-bus read data and a continuous compare against an expected pattern.
module mem_tester #(
  parameter int unsigned base_addr  = 'h80,
  parameter int unsigned addr_size  = 8,
  parameter int unsigned array_size = 4,
  parameter int unsigned word_size  = 8,
  parameter logic [array_size*word_size-1:0] array_content = 32'h0806_0402
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [addr_size-1:0] addr,
  input  logic [word_size-1:0] data_in,
  input  logic                 write_en,
  output logic [word_size-1:0] data_out,
  output logic                 content_ok
);

  // One extra bit so base_addr+array_size == 2**addr_size does not wrap
  localparam int unsigned AW = addr_size + 1;
  localparam int unsigned IW = (array_size > 1) ? $clog2(array_size) : 1;
  localparam logic [AW-1:0] LO = AW'(base_addr);
  localparam logic [AW-1:0] HI = AW'(base_addr + array_size);

  logic [word_size-1:0]  mem [array_size];
  logic [AW-1:0]         addr_x;
  logic                  hit;
  logic [IW-1:0]         idx;
  logic [array_size-1:0] word_eq;

  assign addr_x = {1'b0, addr};
  assign hit    = (addr_x >= LO) && (addr_x < HI);
  assign idx    = IW'(addr_x - LO);

  for (genvar i = 0; i < array_size; i++) begin : g_cmp
    assign word_eq[i] = (mem[i] == array_content[i*word_size +: word_size]);
  end

  // Read mux and compare both sample pre-edge contents (read-before-write)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < array_size; i++) mem[i] <= '0;
      data_out   <= '0;
      content_ok <= 1'b0;
    end else begin
      data_out   <= hit ? mem[idx] : '0;
      content_ok <= &word_eq;
      if (write_en && hit) mem[idx] <= data_in;
    end
  end

endmodule

// File: tb/tb_mem_tester.sv
// Self-checking bench for mem_tester: directed scenarios plus randomized traffic
// against a word-array reference model.
module tb_mem_tester;

  localparam int BASE = 'h80;
  localparam int SIZE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       write_en;
  logic [7:0] data_out;
  logic       content_ok;

  int nchecks = 0;
  int nerr    = 0;

  // Reference model state
  int         mm [SIZE];
  int         pat [SIZE];
  logic [7:0] exp_dout;
  logic       exp_ok;

  mem_tester dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .data_in   (data_in),
    .write_en  (write_en),
    .data_out  (data_out),
    .content_ok(content_ok)
  );

  always #5 clk = ~clk;

  function automatic bit in_win(input int a);
    return (a >= BASE) && (a < BASE + SIZE);
  endfunction

  function automatic bit model_match();
    for (int i = 0; i < SIZE; i++) if (mm[i] != pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive inputs, advance the model across the edge, settle past it
  task automatic cycle(input int a, input int d, input bit we);
    addr     = 8'(a);
    data_in  = 8'(d);
    write_en = we;
    @(posedge clk);
    if (reset) begin
      exp_dout = in_win(a) ? 8'(mm[a - BASE]) : 8'h00;
      exp_ok   = model_match();
      if (we && in_win(a)) mm[a - BASE] = d & 'hFF;
    end
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < SIZE; i++) mm[i] = 0;
    exp_dout = 8'h00;
    exp_ok   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_model();
    repeat (5) cycle(BASE, 'h5A, 1'b1);
    nchecks++;
    if (data_out !== 8'h00) begin nerr++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    nchecks++;
    if (content_ok !== 1'b0) begin nerr++; $display("FAIL reset_ok got=%b exp=0", content_ok); end
    #3 reset = 1'b1;
    for (int a = BASE; a < BASE + SIZE + 1; a++) begin
      cycle(a, 0, 1'b0);
      if (a > BASE) begin
        nchecks++;
        if (data_out !== 8'h00 || content_ok !== 1'b0) begin
          nerr++;
          $display("FAIL reset_read a=%h got=%h/%b exp=00/0", a - 1, data_out, content_ok);
        end
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < SIZE; i++) begin
      cycle(BASE + i, pat[i], 1'b1);
      nchecks++;
      if (content_ok !== exp_ok) begin nerr++; $display("FAIL fill_ok i=%0d got=%b exp=%b", i, content_ok, exp_ok); end
    end
    // Edge after the last write still sees the pre-write content
    nchecks++;
    if (content_ok !== 1'b0) begin nerr++; $display("FAIL fill_early got=%b exp=0", content_ok); end
    cycle(BASE + 2, 0, 1'b0);
    nchecks++;
    if (content_ok !== 1'b1) begin nerr++; $display("FAIL fill_match got=%b exp=1", content_ok); end
    nchecks++;
    if (data_out !== 8'h06) begin nerr++; $display("FAIL fill_read got=%h exp=06", data_out); end
  endtask

  task automatic test_break_restore();
    cycle(BASE + 1, 'h07, 1'b1);
    nchecks++;
    if (content_ok !== 1'b1) begin nerr++; $display("FAIL break_lag got=%b exp=1", content_ok); end
    cycle(0, 0, 1'b0);
    nchecks++;
    if (content_ok !== 1'b0) begin nerr++; $display("FAIL break_ok got=%b exp=0", content_ok); end
    cycle(BASE + 1, 'h04, 1'b1);
    cycle(0, 0, 1'b0);
    nchecks++;
    if (content_ok !== 1'b1) begin nerr++; $display("FAIL restore_ok got=%b exp=1", content_ok); end
  endtask

  task automatic test_out_of_window();
    int rd [3];
    rd[0] = BASE - 1; rd[1] = BASE + SIZE; rd[2] = 0;
    cycle(BASE - 1, 'hFF, 1'b1);
    cycle(BASE + SIZE, 'hFF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(rd[k], 0, 1'b0);
      nchecks++;
      if (data_out !== 8'h00) begin nerr++; $display("FAIL oow_read a=%h got=%h exp=00", rd[k], data_out); end
    end
    for (int i = 0; i < SIZE; i++) begin
      cycle(BASE + i, 0, 1'b0);
      nchecks++;
      if (data_out !== 8'(pat[i])) begin nerr++; $display("FAIL oow_keep i=%0d got=%h exp=%h", i, data_out, 8'(pat[i])); end
    end
    nchecks++;
    if (content_ok !== 1'b1) begin nerr++; $display("FAIL oow_ok got=%b exp=1", content_ok); end
  endtask

  task automatic test_read_during_write();
    cycle(BASE, 'h55, 1'b1);
    nchecks++;
    if (data_out !== 8'h02) begin nerr++; $display("FAIL rdw_old got=%h exp=02", data_out); end
    cycle(BASE, 0, 1'b0);
    nchecks++;
    if (data_out !== 8'h55) begin nerr++; $display("FAIL rdw_new got=%h exp=55", data_out); end
    cycle(BASE, 'h02, 1'b1);
    cycle(0, 0, 1'b0);
  endtask

  task automatic test_random();
    int a, d;
    bit we;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 255);
        default: a = $urandom_range(BASE - 2, BASE + SIZE + 1);
      endcase
      // Bias toward pattern words so the match condition toggles often
      if (in_win(a) && $urandom_range(0, 2) != 0) d = pat[a - BASE];
      else d = $urandom_range(0, 255);
      we = $urandom_range(0, 1);
      cycle(a, d, we);
      nchecks++;
      if (data_out !== exp_dout || content_ok !== exp_ok) begin
        nerr++;
        $display("FAIL rand n=%0d a=%h got=%h/%b exp=%h/%b", n, a, data_out, content_ok, exp_dout, exp_ok);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < SIZE; i++) cycle(BASE + i, pat[i], 1'b1);
    cycle(BASE + 3, 0, 1'b0);
    cycle(BASE + 3, 0, 1'b0);
    nchecks++;
    if (content_ok !== 1'b1 || data_out !== 8'(pat[3])) begin
      nerr++;
      $display("FAIL areset_pre got=%h/%b exp=%h/1", data_out, content_ok, 8'(pat[3]));
    end
    #2 reset = 1'b0;
    clear_model();
    #1;
    nchecks++;
    if (content_ok !== 1'b0 || data_out !== 8'h00) begin
      nerr++;
      $display("FAIL areset_now got=%h/%b exp=00/0", data_out, content_ok);
    end
    #1 reset = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      cycle(BASE + i, 0, 1'b0);
      nchecks++;
      if (data_out !== 8'h00 || content_ok !== 1'b0) begin
        nerr++;
        $display("FAIL areset_read i=%0d got=%h/%b exp=00/0", i, data_out, content_ok);
      end
    end
  endtask

  initial begin
    logic [31:0] content;
    content = 32'h0806_0402;
    for (int i = 0; i < SIZE; i++) pat[i] = int'(content[i*8 +: 8]);
    reset    = 1'b0;
    addr     = 8'h00;
    data_in  = 8'h00;
    write_en = 1'b0;
    clear_model();
    #1;
    test_reset();
    test_fill();
    test_break_restore();
    test_out_of_window();
    test_read_during_write();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
